// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg
//   Shared definitions for the run/step/halt controller: the FSM state
//   encoding, which the debug UART and the bench also decode from the
//   2-bit `state` output.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_bp.sv
// bp_compare
//   Bank of NUM_BP breakpoint comparators. Slot i is hit when it is enabled
//   and its address equals the current pc.
// Ports:
//   pc       in   ADDR_W         address the core executes this cycle
//   bp_addr  in   NUM_BP*ADDR_W  slot i at [i*ADDR_W +: ADDR_W]
//   bp_en    in   NUM_BP         per-slot enable
//   hit      out  NUM_BP         per-slot match vector (combinational)
module bp_compare #(
  parameter int ADDR_W = 32,
  parameter int NUM_BP = 2
) (
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic [NUM_BP-1:0]        hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit[i] = bp_en[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W]);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run/step/halt controller for the simple CPU core. Stretches the board
//   reset into a core reset, generates the core clock-enable, halts on PC
//   breakpoints and counts executed cycles.
// Ports:
//   clk         in   1              system clock, rising edge
//   pcrst       in   1              asynchronous active-low reset
//   pc          in   ADDR_W         address executed when core_ce=1
//   run_req     in   1              resume free-run (honoured in HALT)
//   step_req    in   1              execute one instruction (honoured in HALT)
//   halt_req    in   1              stop (honoured in RUN)
//   bp_addr     in   NUM_BP*ADDR_W  breakpoint addresses
//   bp_en       in   NUM_BP         breakpoint enables
//   cyc_clr     in   1              synchronous clear of cyc_cnt
//   core_rst_n  out  1              core reset, active-low (registered)
//   core_ce     out  1              core clock-enable (combinational)
//   state       out  2              FSM state, RST=0 HALT=1 RUN=2 STEP=3
//   halted      out  1              state==HALT (registered)
//   bp_hit      out  NUM_BP         sticky breakpoint-hit flags
//   cyc_cnt     out  CNT_W          cycles with core_ce=1, wraps
//
// Handshake: run_req/step_req/halt_req are level-sampled every cycle; a
// single-cycle pulse issues one request, a held level re-issues it in every
// cycle where the current state accepts it. There is no ready/ack.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int NUM_BP    = 2,
  parameter int RST_HOLD  = 4,
  parameter int CNT_W     = 32,
  parameter int START_RUN = 1
) (
  input  logic                     clk,
  input  logic                     pcrst,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     run_req,
  input  logic                     step_req,
  input  logic                     halt_req,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic                     cyc_clr,
  output logic                     core_rst_n,
  output logic                     core_ce,
  output logic [1:0]               state,
  output logic                     halted,
  output logic [NUM_BP-1:0]        bp_hit,
  output logic [CNT_W-1:0]         cyc_cnt
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam run_state_e EXIT_ST = (START_RUN != 0) ? ST_RUN : ST_HALT;

  run_state_e        st, st_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [NUM_BP-1:0] hit_vec;
  logic              skip;
  logic              match;
  logic              leave_halt;

  bp_compare #(
    .ADDR_W (ADDR_W),
    .NUM_BP (NUM_BP)
  ) u_bp (
    .pc      (pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .hit     (hit_vec)
  );

  // skip masks breakpoints for the first RUN cycle after leaving HALT so a
  // resume from a breakpoint PC executes that instruction.
  assign match = (|hit_vec) && !skip;
  assign state = st;

  always_comb begin
    st_nxt     = st;
    core_ce    = 1'b0;
    leave_halt = 1'b0;
    case (st)
      ST_RST: begin
        if (hold_cnt == HOLD_LAST) st_nxt = EXIT_ST;
      end
      ST_RUN: begin
        core_ce = !halt_req && !match;
        if (halt_req || match) st_nxt = ST_HALT;
      end
      ST_HALT: begin
        // step has priority when both requests arrive together
        if (step_req) begin
          st_nxt     = ST_STEP;
          leave_halt = 1'b1;
        end else if (run_req) begin
          st_nxt     = ST_RUN;
          leave_halt = 1'b1;
        end
      end
      ST_STEP: begin
        core_ce = 1'b1;
        st_nxt  = ST_HALT;
      end
      default: st_nxt = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      st         <= ST_RST;
      hold_cnt   <= '0;
      core_rst_n <= 1'b0;
      halted     <= 1'b0;
      bp_hit     <= '0;
      skip       <= 1'b0;
      cyc_cnt    <= '0;
    end else begin
      st         <= st_nxt;
      core_rst_n <= (st_nxt != ST_RST);
      halted     <= (st_nxt == ST_HALT);
      if (st == ST_RST) hold_cnt <= hold_cnt + HOLD_W'(1);
      if (leave_halt) begin
        bp_hit <= '0;
        skip   <= 1'b1;
      end else if (st == ST_RUN) begin
        skip <= 1'b0;
        if (match) bp_hit <= bp_hit | hit_vec;
      end
      if (cyc_clr)      cyc_cnt <= '0;
      else if (core_ce) cyc_cnt <= cyc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
//   Directed bench for cpu_run_ctrl with ADDR_W=16, NUM_BP=2, RST_HOLD=4,
//   CNT_W=4 (so the counter wrap is reachable), START_RUN=1. Inputs change
//   1ns after the rising edge, outputs are sampled 1ns later.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int ADDR_W = 16;
  localparam int NUM_BP = 2;
  localparam int CNT_W  = 4;

  logic                     clk = 1'b0;
  logic                     pcrst;
  logic [ADDR_W-1:0]        pc;
  logic                     run_req, step_req, halt_req, cyc_clr;
  logic [NUM_BP*ADDR_W-1:0] bp_addr;
  logic [NUM_BP-1:0]        bp_en;
  logic                     core_rst_n, core_ce, halted;
  logic [1:0]               state;
  logic [NUM_BP-1:0]        bp_hit;
  logic [CNT_W-1:0]         cyc_cnt;

  int tests = 0;
  int fails = 0;

  cpu_run_ctrl #(
    .ADDR_W (ADDR_W), .NUM_BP (NUM_BP), .RST_HOLD (4),
    .CNT_W (CNT_W), .START_RUN (1)
  ) dut (
    .clk (clk), .pcrst (pcrst), .pc (pc), .run_req (run_req),
    .step_req (step_req), .halt_req (halt_req), .bp_addr (bp_addr),
    .bp_en (bp_en), .cyc_clr (cyc_clr), .core_rst_n (core_rst_n),
    .core_ce (core_ce), .state (state), .halted (halted),
    .bp_hit (bp_hit), .cyc_cnt (cyc_cnt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pcrst = 1'b0; pc = 16'h0000; run_req = 0; step_req = 0; halt_req = 0;
    cyc_clr = 0; bp_addr = '0; bp_en = '0;
    tick(); tick();
    #1;
    tests++; if (state !== 2'(ST_RST) || core_rst_n !== 1'b0 || core_ce !== 1'b0) begin
      fails++; $display("FAIL reset_state: state=%0d rst_n=%0b ce=%0b want 0/0/0", state, core_rst_n, core_ce); end
    tests++; if (halted !== 1'b0 || bp_hit !== 2'b00 || cyc_cnt !== 4'd0) begin
      fails++; $display("FAIL reset_flags: halted=%0b bp_hit=%b cyc=%0d want 0/00/0", halted, bp_hit, cyc_cnt); end
    tick();
    pcrst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++; if (core_rst_n !== (i == 4)) begin
        fails++; $display("FAIL release_rst_n[%0d]: got %0b want %0b", i, core_rst_n, (i == 4)); end
    end
    tests++; if (state !== 2'(ST_RUN) || core_ce !== 1'b1 || cyc_cnt !== 4'd0) begin
      fails++; $display("FAIL release_run: state=%0d ce=%0b cyc=%0d want 2/1/0", state, core_ce, cyc_cnt); end
    for (int j = 1; j <= 3; j++) begin
      tick();
      tests++; if (cyc_cnt !== 4'(j)) begin
        fails++; $display("FAIL run_count[%0d]: got %0d want %0d", j, cyc_cnt, j); end
    end
  endtask

  task automatic test_breakpoint();
    bp_addr = {16'h0099, 16'h0010};
    bp_en   = 2'b01;
    pc      = 16'h0004;
    cyc_clr = 1'b1;
    tick();
    cyc_clr = 1'b0; pc = 16'h0008;
    #1;
    tests++; if (cyc_cnt !== 4'd0 || core_ce !== 1'b1) begin
      fails++; $display("FAIL bp_clr: cyc=%0d ce=%0b want 0/1", cyc_cnt, core_ce); end
    tick(); pc = 16'h000C; #1;
    tests++; if (cyc_cnt !== 4'd1) begin
      fails++; $display("FAIL bp_cnt1: got %0d want 1", cyc_cnt); end
    tick(); pc = 16'h0010; #1;
    tests++; if (core_ce !== 1'b0 || cyc_cnt !== 4'd2 || state !== 2'(ST_RUN)) begin
      fails++; $display("FAIL bp_match_cycle: ce=%0b cyc=%0d state=%0d want 0/2/2", core_ce, cyc_cnt, state); end
    tick();
    tests++; if (state !== 2'(ST_HALT) || halted !== 1'b1 || bp_hit !== 2'b01 || core_ce !== 1'b0) begin
      fails++; $display("FAIL bp_halt: state=%0d halted=%0b bp_hit=%b ce=%0b want 1/1/01/0", state, halted, bp_hit, core_ce); end
    tick();
    tests++; if (cyc_cnt !== 4'd2) begin
      fails++; $display("FAIL bp_frozen: got %0d want 2", cyc_cnt); end
  endtask

  task automatic test_resume();
    run_req = 1'b1; #1;
    tests++; if (core_ce !== 1'b0) begin
      fails++; $display("FAIL resume_halt_ce: got %0b want 0", core_ce); end
    tick(); run_req = 1'b0; #1;
    tests++; if (state !== 2'(ST_RUN) || bp_hit !== 2'b00 || core_ce !== 1'b1) begin
      fails++; $display("FAIL resume_skip: state=%0d bp_hit=%b ce=%0b want 2/00/1", state, bp_hit, core_ce); end
    tick(); pc = 16'h0014; #1;
    tests++; if (state !== 2'(ST_RUN) || core_ce !== 1'b1 || cyc_cnt !== 4'd3) begin
      fails++; $display("FAIL resume_run: state=%0d ce=%0b cyc=%0d want 2/1/3", state, core_ce, cyc_cnt); end
    tick();
    tests++; if (cyc_cnt !== 4'd4) begin
      fails++; $display("FAIL resume_cnt: got %0d want 4", cyc_cnt); end
    // skip has expired, so the breakpoint fires again
    pc = 16'h0010; #1;
    tests++; if (core_ce !== 1'b0) begin
      fails++; $display("FAIL rehalt_ce: got %0b want 0", core_ce); end
    tick();
    tests++; if (state !== 2'(ST_HALT) || bp_hit !== 2'b01 || cyc_cnt !== 4'd4) begin
      fails++; $display("FAIL rehalt: state=%0d bp_hit=%b cyc=%0d want 1/01/4", state, bp_hit, cyc_cnt); end
  endtask

  task automatic test_single_step();
    int pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0; #1;
      if (core_ce === 1'b1) pulses++;
      tests++; if (state !== 2'(ST_STEP) || core_ce !== 1'b1 || bp_hit !== 2'b00) begin
        fails++; $display("FAIL step_pulse[%0d]: state=%0d ce=%0b bp_hit=%b want 3/1/00", k, state, core_ce, bp_hit); end
      tick();
      tests++; if (state !== 2'(ST_HALT) || core_ce !== 1'b0 || cyc_cnt !== 4'(5 + k)) begin
        fails++; $display("FAIL step_back[%0d]: state=%0d ce=%0b cyc=%0d want 1/0/%0d", k, state, core_ce, cyc_cnt, 5 + k); end
      for (int w = 0; w < 3; w++) begin
        tick();
        if (core_ce === 1'b1) pulses++;
      end
    end
    tests++; if (pulses != 3) begin
      fails++; $display("FAIL step_count: got %0d pulses want 3", pulses); end
  endtask

  task automatic test_collisions();
    pc = 16'h0020;
    run_req = 1'b1; step_req = 1'b1;
    tick();
    run_req = 1'b0; step_req = 1'b0; #1;
    tests++; if (state !== 2'(ST_STEP) || core_ce !== 1'b1) begin
      fails++; $display("FAIL coll_step: state=%0d ce=%0b want 3/1", state, core_ce); end
    tick();
    tests++; if (state !== 2'(ST_HALT) || cyc_cnt !== 4'd8) begin
      fails++; $display("FAIL coll_back: state=%0d cyc=%0d want 1/8", state, cyc_cnt); end
    run_req = 1'b1; tick(); run_req = 1'b0; #1;
    halt_req = 1'b1; #1;
    tests++; if (core_ce !== 1'b0) begin
      fails++; $display("FAIL halt_req_ce: got %0b want 0", core_ce); end
    tick(); halt_req = 1'b0; #1;
    tests++; if (state !== 2'(ST_HALT) || halted !== 1'b1 || cyc_cnt !== 4'd8) begin
      fails++; $display("FAIL halt_req: state=%0d halted=%0b cyc=%0d want 1/1/8", state, halted, cyc_cnt); end
    run_req = 1'b1; tick(); run_req = 1'b0; #1;
    tests++; if (state !== 2'(ST_RUN) || core_ce !== 1'b1 || cyc_cnt !== 4'd8) begin
      fails++; $display("FAIL clr_pre: state=%0d ce=%0b cyc=%0d want 2/1/8", state, core_ce, cyc_cnt); end
    cyc_clr = 1'b1; tick(); cyc_clr = 1'b0; #1;
    tests++; if (cyc_cnt !== 4'd0) begin
      fails++; $display("FAIL clr_wins: got %0d want 0", cyc_cnt); end
    for (int i = 0; i < 15; i++) tick();
    tests++; if (cyc_cnt !== 4'd15) begin
      fails++; $display("FAIL wrap_pre: got %0d want 15", cyc_cnt); end
    tick();
    tests++; if (cyc_cnt !== 4'd0) begin
      fails++; $display("FAIL wrap: got %0d want 0", cyc_cnt); end
  endtask

  task automatic test_reset_mid_run();
    tick(); tick();
    #1 pcrst = 1'b0;
    #1;
    tests++; if (state !== 2'(ST_RST) || core_rst_n !== 1'b0 || core_ce !== 1'b0) begin
      fails++; $display("FAIL mid_rst: state=%0d rst_n=%0b ce=%0b want 0/0/0", state, core_rst_n, core_ce); end
    tests++; if (cyc_cnt !== 4'd0 || bp_hit !== 2'b00 || halted !== 1'b0) begin
      fails++; $display("FAIL mid_rst_flags: cyc=%0d bp_hit=%b halted=%0b want 0/00/0", cyc_cnt, bp_hit, halted); end
    #1 pcrst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++; if (core_rst_n !== (i == 4)) begin
        fails++; $display("FAIL mid_release[%0d]: got %0b want %0b", i, core_rst_n, (i == 4)); end
    end
    tests++; if (state !== 2'(ST_RUN) || core_ce !== 1'b1) begin
      fails++; $display("FAIL mid_run: state=%0d ce=%0b want 2/1", state, core_ce); end
    // both slots on the same address: both flags must latch
    bp_addr = {16'h0030, 16'h0030}; bp_en = 2'b11; pc = 16'h0030; #1;
    tests++; if (core_ce !== 1'b0) begin
      fails++; $display("FAIL dual_bp_ce: got %0b want 0", core_ce); end
    tick();
    tests++; if (bp_hit !== 2'b11 || halted !== 1'b1) begin
      fails++; $display("FAIL dual_bp: bp_hit=%b halted=%0b want 11/1", bp_hit, halted); end
    #1 pcrst = 1'b0;
    #1;
    tests++; if (bp_hit !== 2'b00 || halted !== 1'b0 || state !== 2'(ST_RST)) begin
      fails++; $display("FAIL halt_rst: bp_hit=%b halted=%0b state=%0d want 00/0/0", bp_hit, halted, state); end
    #1 pcrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_breakpoint();
    test_resume();
    test_single_step();
    test_collisions();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
